inst_load_ctrl: RTL and testbench
=================================

# inst_load_ctrl

Sequences the host-driven loading of the instruction RAM before the RISC-Q core runs. It accepts a length header and a stream of 32-bit instruction words over a valid/ready handshake, then drives the RAM write port with sequential addresses. It holds the core in reset during loading and issues the one-cycle init-done pulse that returns the instruction RAM to fetch mode. It sits between the host interface and the instruction RAM's write/init ports.

## Interface
- ADDR_W, 12, instruction RAM address width
- DEPTH, 4096, maximum loadable words (≤ 2^ADDR_W)
- i_clk  in  1  sole clock
- i_rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset (fixed)
- i_start  in  1  one-cycle request to begin a load (sampled in IDLE, DONE, ERR)
- i_host_valid  in  1  host word valid
- o_host_ready  out  1  controller accepts word
- i_host_data  in  32  header / instruction / checksum word
- i_host_last  in  1  host marks final word of stream
- o_we  out  1  RAM write enable
- o_waddr  out  ADDR_W  RAM write address
- o_wdata  out  32  RAM write data
- o_init_done  out  1  one-cycle pulse, load complete
- o_cpu_rst  out  1  core reset request (high while not DONE)
- o_busy  out  1  load in progress
- o_err  out  1  load failed, sticky until restart

## Operation
- States: IDLE, HDR, LOAD, CKSUM, FLUSH, DONE, ERR. A handshake occurs when valid and ready are both high on a rising edge.
- o_host_ready = 1 exactly in HDR, LOAD, CKSUM. o_busy = 1 in HDR, LOAD, CKSUM, FLUSH.
- IDLE/DONE/ERR + i_start -> HDR. This clears the word counter, checksum and o_err, and sets o_cpu_rst=1. i_start in other states is ignored.
- HDR handshake: len = i_host_data[ADDR_W:0] (ADDR_W+1 bits).
  - len==0 or len>DEPTH -> ERR.
  - i_host_last=1 on the header -> ERR.
  - Otherwise -> LOAD.
- LOAD handshake k (k = 0..len-1): next cycle o_we=1, o_waddr=k, o_wdata=word. The checksum is updated as cksum ^= word.
- i_host_last must be high on word len-1 and low on all others. Any mismatch -> ERR; the offending word is not written.
- After word len-1: go to CKSUM if the macro is defined, otherwise to FLUSH.
- CKSUM handshake: word == cksum -> FLUSH; otherwise -> ERR. i_host_last is don't-care here.
- FLUSH (1 cycle) -> DONE. On entry to DONE, o_init_done=1 for one cycle and o_cpu_rst drops to 0.
- ERR: o_err=1 and o_cpu_rst=1, held until i_start or i_rst.
- The counter is ADDR_W+1 bits, so len=DEPTH=4096 is reached without wrap. o_waddr carries the low ADDR_W bits of k.
- i_rst in any state, including mid-load, returns the block to IDLE with reset outputs. RAM contents are then undefined and the host must restart with i_start.

## Timing
- Reset values:
  - state=IDLE
  - o_host_ready=0, o_we=0, o_waddr=0, o_wdata=0
  - o_init_done=0, o_cpu_rst=1, o_busy=0, o_err=0
- i_start at cycle t puts the block in HDR at t+1, with o_host_ready=1 at t+1.
- Write latency is 1: a data handshake at T gives o_we at T+1. There is no back-pressure from the RAM, so one word per cycle is sustained.
- Final accepted word (last data word, or the checksum word when the macro is defined) at T:
  - T+1: FLUSH, last o_we if it was a data word
  - T+2: DONE, o_init_done pulse
  - This guarantees the final write lands a cycle before the RAM leaves init mode.
- Error handshake at T: ERR from T+1, no write.
- All outputs are registered, except o_host_ready and o_busy, which decode directly from the state register.

## Configuration
- INST_LOAD_CKSUM_EN defined:
  - CKSUM state present.
  - The host appends an XOR-of-all-data-words word after the last instruction.
  - A mismatch leads to ERR.
- INST_LOAD_CKSUM_EN undefined:
  - CKSUM state and checksum register are removed.
  - LOAD goes to FLUSH directly after word len-1.

## Test plan
- Basic load, macro off: start, header 3, words 0xA0,0xA1,0xA2 (last on 0xA2).
  - Writes at addresses 0,1,2 on consecutive cycles.
  - o_init_done 2 cycles after the 0xA2 handshake; o_cpu_rst 0.
- Checksum, macro on:
  - Header 2, words 0x0F,0xF0, checksum 0xFF -> DONE.
  - Repeat with checksum 0xFE -> o_err=1, no o_init_done, o_cpu_rst stays 1.
- Bad header: header 0, then header 4097 -> ERR each time, no o_we.
- Last-flag misuse: header 4, last asserted on word 2 -> ERR, only addresses 0,1 written.
- Full depth with random valid gaps: header 4096 -> final write at address 0xFFF, o_init_done once, no address wrap.
- Reset mid-load: i_rst after word 5 of 10 -> IDLE, all outputs at reset values. A new start plus a 1-word load completes normally.

Source files
------------

// File: rtl/inst_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// inst_load_ctrl_if
// Host-to-loader word stream: a valid/ready handshake carrying 32-bit header,
// instruction and checksum words, with a last-word marker.
//   valid : host word valid                 (host -> loader)
//   data  : header / instruction / checksum (host -> loader)
//   last  : host marks final word of stream (host -> loader)
//   ready : loader accepts word             (loader -> host)
// master = host side, slave = loader side.
// -----------------------------------------------------------------------------
interface inst_load_ctrl_if;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic        last;

   modport master (output valid, output data, output last, input  ready);
   modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/inst_load_ctrl.sv
// -----------------------------------------------------------------------------
// inst_load_ctrl
// Sequences host-driven loading of the instruction RAM before the core runs.
// Accepts a length header and a stream of instruction words, writes them to
// sequential RAM addresses, holds the core in reset while loading and pulses
// o_init_done once the last write has landed.
//
// Optional feature macro: INST_LOAD_CKSUM_EN
//   defined   : host appends an XOR-of-all-data-words word; mismatch -> ERR
//   undefined : no checksum state/register, LOAD goes straight to FLUSH
//
// Ports
//   i_clk        : sole clock
//   i_rst        : synchronous active-high reset
//   i_start      : one-cycle load request (honoured in IDLE, DONE, ERR)
//   host         : host word stream (slave side of inst_load_ctrl_if)
//   o_we         : RAM write enable
//   o_waddr      : RAM write address
//   o_wdata      : RAM write data
//   o_init_done  : one-cycle pulse, load complete
//   o_cpu_rst    : core reset request (high while not DONE)
//   o_busy       : load in progress
//   o_err        : load failed, sticky until restart
// -----------------------------------------------------------------------------
module inst_load_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   inst_load_ctrl_if.slave     host,
   output logic                o_we,
   output logic [ADDR_W-1:0]   o_waddr,
   output logic [31:0]         o_wdata,
   output logic                o_init_done,
   output logic                o_cpu_rst,
   output logic                o_busy,
   output logic                o_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
`ifdef INST_LOAD_CKSUM_EN
   localparam logic [2:0] S_CKSUM = 3'd3;
`endif
   localparam logic [2:0] S_FLUSH = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   logic [2:0]      state;
   // One bit wider than the address so a full-depth load never wraps.
   logic [ADDR_W:0] cnt;
   logic [ADDR_W:0] last_idx;
   logic [ADDR_W:0] hdr_len;
   logic            hs;
   logic            hdr_bad;
   logic            is_final;
`ifdef INST_LOAD_CKSUM_EN
   logic [31:0]     cksum;
`endif

   // ready and busy decode straight from the state register
   always_comb begin
      host.ready = 1'b0;
      o_busy     = 1'b0;
      case (state)
         S_HDR, S_LOAD: begin
            host.ready = 1'b1;
            o_busy     = 1'b1;
         end
`ifdef INST_LOAD_CKSUM_EN
         S_CKSUM: begin
            host.ready = 1'b1;
            o_busy     = 1'b1;
         end
`endif
         S_FLUSH: o_busy = 1'b1;
         default: ;
      endcase
   end

   assign hs       = host.valid & host.ready;
   assign hdr_len  = host.data[ADDR_W:0];
   assign hdr_bad  = (hdr_len == '0) || (hdr_len > DEPTH_C) || host.last;
   assign is_final = (cnt == last_idx);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_idx    <= '0;
         o_we        <= 1'b0;
         o_waddr     <= '0;
         o_wdata     <= '0;
         o_init_done <= 1'b0;
         o_cpu_rst   <= 1'b1;
         o_err       <= 1'b0;
`ifdef INST_LOAD_CKSUM_EN
         cksum       <= '0;
`endif
      end else begin
         o_we        <= 1'b0;
         o_init_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (i_start) begin
                  state     <= S_HDR;
                  cnt       <= '0;
                  o_err     <= 1'b0;
                  o_cpu_rst <= 1'b1;
`ifdef INST_LOAD_CKSUM_EN
                  cksum     <= '0;
`endif
               end
            end
            S_HDR: begin
               if (hs) begin
                  last_idx <= hdr_len - ONE_C;
                  if (hdr_bad) begin
                     state <= S_ERR;
                     o_err <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (hs) begin
                  // last must be high on exactly the final word; a misplaced
                  // or missing marker aborts without writing that word
                  if (host.last != is_final) begin
                     state <= S_ERR;
                     o_err <= 1'b1;
                  end else begin
                     o_we    <= 1'b1;
                     o_waddr <= cnt[ADDR_W-1:0];
                     o_wdata <= host.data;
                     cnt     <= cnt + ONE_C;
`ifdef INST_LOAD_CKSUM_EN
                     cksum   <= cksum ^ host.data;
                     if (is_final) state <= S_CKSUM;
`else
                     if (is_final) state <= S_FLUSH;
`endif
                  end
               end
            end
`ifdef INST_LOAD_CKSUM_EN
            S_CKSUM: begin
               if (hs) begin
                  if (host.data == cksum) begin
                     state <= S_FLUSH;
                  end else begin
                     state <= S_ERR;
                     o_err <= 1'b1;
                  end
               end
            end
`endif
            // FLUSH lets the final write land before the RAM leaves init mode
            S_FLUSH: begin
               state       <= S_DONE;
               o_init_done <= 1'b1;
               o_cpu_rst   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_load_ctrl
// Self-checking bench for inst_load_ctrl. Expected RAM writes are queued when
// each data word is handed to the DUT and popped by a monitor as o_we fires.
// Builds with or without INST_LOAD_CKSUM_EN.
// -----------------------------------------------------------------------------
module tb_inst_load_ctrl;

   typedef struct packed {
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        we;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        init_done;
   logic        cpu_rst;
   logic        busy;
   logic        err;

   wr_t exp_q[$];
   int  we_cyc_q[$];
   int  checks   = 0;
   int  errors   = 0;
   int  init_cnt = 0;
   int  cyc      = 0;

   inst_load_ctrl_if hif();

   inst_load_ctrl #(.ADDR_W(12), .DEPTH(4096)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .host        (hif),
      .o_we        (we),
      .o_waddr     (waddr),
      .o_wdata     (wdata),
      .o_init_done (init_done),
      .o_cpu_rst   (cpu_rst),
      .o_busy      (busy),
      .o_err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor / scoreboard
   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (!rst && we) begin
         we_cyc_q.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", waddr, wdata);
         end else begin
            e = exp_q.pop_front();
            if (waddr !== e.a || wdata !== e.d) begin
               errors++;
               $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                        waddr, wdata, e.a, e.d);
            end
         end
      end
      if (!rst && init_done) init_cnt++;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic l, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      hif.valid = 1'b1;
      hif.data  = d;
      hif.last  = l;
      n = 0;
      while (hif.ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got ready=0 for 50 cycles, required ready=1");
      end
      @(posedge clk); #1;
      hif.valid = 1'b0;
      hif.last  = 1'b0;
   endtask

   task automatic send_data(input int k, input logic [31:0] d, input logic l, input int gap);
      exp_q.push_back({k[11:0], d});
      send(d, l, gap);
   endtask

   // checksum word only exists in the checksum build
   task automatic send_tail(input logic [31:0] x);
`ifdef INST_LOAD_CKSUM_EN
      send(x, 1'b0, 0);
`else
      if (x === 32'hx) $display("unused");
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      hif.valid = 1'b0; hif.data = '0; hif.last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({hif.ready, we, busy, init_done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/we/busy/init=%b, required 0000", {hif.ready, we, busy, init_done});
      end
      checks++;
      if ({waddr, wdata} !== 44'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h data=%h, required 0/0", waddr, wdata);
      end
      checks++;
      if ({cpu_rst, err} !== 2'b10) begin
         errors++;
         $display("FAIL reset_status: got cpu_rst/err=%b, required 10", {cpu_rst, err});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int i0;
      i0 = init_cnt;
      do_start();
      @(negedge clk);
      checks++;
      if ({hif.ready, busy, cpu_rst} !== 3'b111) begin
         errors++;
         $display("FAIL basic_hdr: got ready/busy/cpu_rst=%b, required 111", {hif.ready, busy, cpu_rst});
      end
      we_cyc_q.delete();
      send(32'd3, 1'b0, 0);
      send_data(0, 32'hA0, 1'b0, 0);
      send_data(1, 32'hA1, 1'b0, 0);
      send_data(2, 32'hA2, 1'b1, 0);
      send_tail(32'hA3);
      @(negedge clk);
      checks++;
      if ({busy, init_done} !== 2'b10) begin
         errors++;
         $display("FAIL basic_flush: got busy/init=%b, required 10", {busy, init_done});
      end
      @(negedge clk);
      checks++;
      if ({init_done, cpu_rst, busy, err} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_done: got init/cpu_rst/busy/err=%b, required 1000", {init_done, cpu_rst, busy, err});
      end
      @(negedge clk);
      checks++;
      if (init_cnt - i0 !== 1 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse: got pulses=%0d init=%b, required 1 and 0", init_cnt - i0, init_done);
      end
      checks++;
      if (we_cyc_q.size() != 3 || we_cyc_q[1] - we_cyc_q[0] != 1 || we_cyc_q[2] - we_cyc_q[1] != 1) begin
         errors++;
         $display("FAIL basic_consecutive: got %0d writes, required 3 on consecutive cycles", we_cyc_q.size());
      end
   endtask

`ifdef INST_LOAD_CKSUM_EN
   task automatic test_cksum();
      int i0;
      i0 = init_cnt;
      do_start();
      send(32'd2, 1'b0, 0);
      send_data(0, 32'h0F, 1'b0, 0);
      send_data(1, 32'hF0, 1'b1, 0);
      send(32'hFF, 1'b0, 0);
      repeat (2) @(negedge clk);
      checks++;
      if ({init_done, cpu_rst, err} !== 3'b100) begin
         errors++;
         $display("FAIL cksum_good: got init/cpu_rst/err=%b, required 100", {init_done, cpu_rst, err});
      end
      i0 = init_cnt;
      do_start();
      send(32'd2, 1'b0, 0);
      send_data(0, 32'h0F, 1'b0, 0);
      send_data(1, 32'hF0, 1'b1, 0);
      send(32'hFE, 1'b0, 0);
      @(negedge clk);
      checks++;
      if ({err, cpu_rst, busy} !== 3'b110) begin
         errors++;
         $display("FAIL cksum_bad: got err/cpu_rst/busy=%b, required 110", {err, cpu_rst, busy});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (init_cnt - i0 !== 0 || cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL cksum_bad_nodone: got pulses=%0d cpu_rst=%b, required 0 and 1", init_cnt - i0, cpu_rst);
      end
   endtask
`endif

   task automatic test_bad_header();
      do_start();
      send(32'd0, 1'b0, 0);
      @(negedge clk);
      checks++;
      if ({err, busy, cpu_rst} !== 3'b101) begin
         errors++;
         $display("FAIL hdr_zero: got err/busy/cpu_rst=%b, required 101", {err, busy, cpu_rst});
      end
      do_start();
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got err=%b, required 0", err);
      end
      send(32'd4097, 1'b0, 0);
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL hdr_too_big: got err/busy=%b, required 10", {err, busy});
      end
      do_start();
      send(32'd2, 1'b1, 0);
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL hdr_last: got err=%b, required 1", err);
      end
   endtask

   task automatic test_last_misuse();
      do_start();
      send(32'd4, 1'b0, 0);
      send_data(0, 32'h100, 1'b0, 0);
      send_data(1, 32'h101, 1'b0, 0);
      send(32'h102, 1'b1, 0);
      @(negedge clk);
      checks++;
      if ({err, we, waddr} !== {1'b1, 1'b0, 12'h001}) begin
         errors++;
         $display("FAIL last_early: got err=%b we=%b addr=%h, required 1 0 001", err, we, waddr);
      end
      do_start();
      send(32'd2, 1'b0, 0);
      send_data(0, 32'h200, 1'b0, 0);
      send(32'h201, 1'b0, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (err !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL last_missing: got err=%b pending=%0d, required 1 and 0", err, exp_q.size());
      end
   endtask

   task automatic test_full_depth();
      int i0;
      logic [31:0] d, x;
      i0 = init_cnt;
      x = '0;
      do_start();
      send(32'd4096, 1'b0, 0);
      for (int k = 0; k < 4096; k++) begin
         d = $urandom;
         x = x ^ d;
         send_data(k, d, (k == 4095), $urandom_range(0, 2));
      end
      send_tail(x);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || waddr !== 12'hFFF) begin
         errors++;
         $display("FAIL full_flush: got busy=%b addr=%h, required 1 FFF", busy, waddr);
      end
      @(negedge clk);
      checks++;
      if ({init_done, cpu_rst} !== 2'b10) begin
         errors++;
         $display("FAIL full_done: got init/cpu_rst=%b, required 10", {init_done, cpu_rst});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (init_cnt - i0 !== 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_count: got pulses=%0d pending=%0d, required 1 and 0", init_cnt - i0, exp_q.size());
      end
   endtask

   task automatic test_reset_midload();
      do_start();
      send(32'd10, 1'b0, 0);
      for (int k = 0; k < 5; k++) send_data(k, 32'h300 + k, 1'b0, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({hif.ready, we, init_done, cpu_rst, busy, err, waddr, wdata} !== {6'b000100, 44'h0}) begin
         errors++;
         $display("FAIL midload_reset: got ready/we/init/cpu/busy/err=%b addr=%h data=%h, required 000100 0 0",
                  {hif.ready, we, init_done, cpu_rst, busy, err}, waddr, wdata);
      end
      do_start();
      send(32'd1, 1'b0, 0);
      send_data(0, 32'hCAFE, 1'b1, 0);
      send_tail(32'hCAFE);
      repeat (2) @(negedge clk);
      checks++;
      if ({init_done, cpu_rst, err} !== 3'b100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload_after_reset: got init/cpu/err=%b pending=%0d, required 100 and 0",
                  {init_done, cpu_rst, err}, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
`ifdef INST_LOAD_CKSUM_EN
      test_cksum();
`endif
      test_bad_header();
      test_last_misuse();
      test_full_depth();
      test_reset_midload();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
